// File: rtl/pla_b3_pkg.sv
// Shared types for the PLA output change queue: word width, FSM states and the
// queued entry layout.
package pla_b3_pkg;

    localparam int Z_W         = 20;
    // Entry stamps are stored at this width; the top uses the low STAMP_W bits.
    localparam int STAMP_MAX_W = 16;

    typedef enum logic {
        UNPRIMED = 1'b0,
        PRIMED   = 1'b1
    } state_t;

    typedef struct packed {
        logic [Z_W-1:0]         z;
        logic [Z_W-1:0]         diff;
        logic [STAMP_MAX_W-1:0] stamp;
    } entry_t;

endpackage

// File: rtl/pla_b3_sync_fifo.sv
// Single-clock FIFO with registered storage. It reports a drop when a push
// meets a full queue that is not being popped in the same cycle.
module pla_b3_sync_fifo
    import pla_b3_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic empty,
    output logic full,
    output logic drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full queue can still take a push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pla_b3_change_queue.sv
// Watches a PLA output word, queues every change with its changed-bit mask
// and sample stamp, and counts entries lost to a full queue.
module pla_b3_change_queue
    import pla_b3_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [Z_W-1:0]     in_z,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Z_W-1:0]     out_z,
    output logic [Z_W-1:0]     out_diff,
    output logic [STAMP_W-1:0] out_stamp,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [Z_W-1:0]     last_z;
    logic [STAMP_W-1:0] sample_cnt;
    logic               enq;
    entry_t             enq_entry;
    entry_t             head;
    logic               empty;
    logic               full;
    logic               drop;
    logic               unused_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNPRIMED;
        else        state <= state_nxt;
    end

    // Clear wins over a same-cycle sample; the first sample seeds last_z and
    // is always queued with diff equal to the word itself.
    always_comb begin
        state_nxt       = state;
        enq             = 1'b0;
        enq_entry.z     = in_z;
        enq_entry.diff  = in_z ^ last_z;
        enq_entry.stamp = STAMP_MAX_W'(sample_cnt);
        if (clear) begin
            state_nxt = UNPRIMED;
        end else if (in_valid) begin
            state_nxt = PRIMED;
            case (state)
                UNPRIMED: begin
                    enq            = 1'b1;
                    enq_entry.diff = in_z;
                end
                PRIMED:   enq = (in_z != last_z);
                default:  enq = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_z     <= '0;
            sample_cnt <= '0;
        end else if (clear) begin
            last_z     <= '0;
            sample_cnt <= '0;
        end else if (in_valid) begin
            last_z     <= in_z;
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    pla_b3_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (enq),
        .wr_data (enq_entry),
        .pop     (out_valid && out_ready),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .drop    (drop)
    );

    assign out_valid   = !empty;
    assign out_z       = head.z;
    assign out_diff    = head.diff;
    assign out_stamp   = head.stamp[STAMP_W-1:0];
    // Upper stamp bits and the full flag are not needed at this level.
    assign unused_head = ^{head.stamp, full};

endmodule

// File: tb/tb_pla_b3_change_queue.sv
// Randomized bench for pla_b3_change_queue against a queue-based model, plus
// directed scenarios with literal expectations.
module tb_pla_b3_change_queue;

    localparam int DEPTH   = 4;
    localparam int STAMP_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [19:0]        in_z = '0;
    logic               clear = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [19:0]        out_z;
    logic [19:0]        out_diff;
    logic [STAMP_W-1:0] out_stamp;
    logic               overflow;
    logic [7:0]         drop_cnt;

    int checks = 0;
    int errors = 0;

    pla_b3_change_queue #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_z      (in_z),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_diff  (out_diff),
        .out_stamp (out_stamp),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] z;
        logic [19:0] diff;
        int          stamp;
    } ment_t;

    ment_t       mq[$];
    bit          m_primed;
    logic [19:0] m_last;
    int          m_cnt;
    bit          m_ovf;
    int          m_drop;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_primed = 1'b0;
        m_last   = '0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    // One clock of the reference behaviour, evaluated on the inputs of the edge.
    task automatic model_clock();
        bit    pop;
        bit    enq;
        ment_t e;
        if (clear) begin
            model_reset();
        end else begin
            pop = (mq.size() != 0) && out_ready;
            enq = 1'b0;
            e   = '{z: '0, diff: '0, stamp: 0};
            if (in_valid) begin
                if (!m_primed || in_z != m_last) begin
                    enq     = 1'b1;
                    e.z     = in_z;
                    e.diff  = m_primed ? (in_z ^ m_last) : in_z;
                    e.stamp = m_cnt;
                end
                m_last   = in_z;
                m_primed = 1'b1;
                m_cnt    = (m_cnt + 1) % (1 << STAMP_W);
            end
            if (pop) void'(mq.pop_front());
            if (enq) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [19:0] z, input logic clr, input logic rdy);
        in_valid  = v;
        in_z      = z;
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_out_z", 32'(out_z), 32'(mq[0].z));
                chk("m_out_diff", 32'(out_diff), 32'(mq[0].diff));
                chk("m_out_stamp", 32'(out_stamp), 32'(mq[0].stamp));
            end
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    initial begin
        logic [19:0] pool [4];
        logic [19:0] rz;
        pool[0] = 20'h00000; pool[1] = 20'h00001; pool[2] = 20'h80000; pool[3] = 20'hFFFFF;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_diff", 32'(out_diff), 32'd0);
        chk("rst_out_stamp", 32'(out_stamp), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // First sample after reset appears on the next cycle.
        step(1'b1, 20'h00001, 1'b0, 1'b0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_z", 32'(out_z), 32'h00001);
        chk("first_diff", 32'(out_diff), 32'h00001);
        chk("first_stamp", 32'(out_stamp), 32'd0);

        // Repeated word is suppressed but still consumes a stamp.
        step(1'b0, 20'h0, 1'b1, 1'b0);
        step(1'b1, 20'h00010, 1'b0, 1'b0);
        step(1'b1, 20'h00010, 1'b0, 1'b0);
        step(1'b1, 20'h00030, 1'b0, 1'b0);
        chk("dup_head_stamp", 32'(out_stamp), 32'd0);
        chk("dup_head_diff", 32'(out_diff), 32'h00010);
        step(1'b0, 20'h0, 1'b0, 1'b1);
        chk("dup_second_stamp", 32'(out_stamp), 32'd2);
        chk("dup_second_diff", 32'(out_diff), 32'h00020);
        chk("dup_second_z", 32'(out_z), 32'h00030);
        step(1'b0, 20'h0, 1'b0, 1'b1);
        chk("dup_drained", 32'(out_valid), 32'd0);

        // Six distinct samples into four slots.
        step(1'b0, 20'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 20'h00100 + 20'(i), 1'b0, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("ovf_head_stamp", 32'(out_stamp), 32'd0);

        // Full queue with simultaneous pop and push: nothing lost.
        step(1'b1, 20'h00200, 1'b0, 1'b1);
        chk("fullpop_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("fullpop_head_stamp", 32'(out_stamp), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 20'h0, 1'b0, 1'b1);
        chk("fullpop_last_stamp", 32'(mq.size()), 32'd0);
        chk("fullpop_empty", 32'(out_valid), 32'd0);

        // Clear beats a same-cycle sample and a pending queue.
        for (int i = 0; i < 3; i++) step(1'b1, 20'h00300 + 20'(i), 1'b0, 1'b0);
        step(1'b1, 20'h00077, 1'b1, 1'b1);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        step(1'b1, 20'h00055, 1'b0, 1'b0);
        chk("clr_stamp", 32'(out_stamp), 32'd0);
        chk("clr_diff", 32'(out_diff), 32'h00055);

        // Randomized traffic, long enough to wrap the stamp counter.
        for (int i = 0; i < 7000; i++) begin
            rz = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 3)] : 20'($urandom);
            step($urandom_range(0, 9) < 8, rz, $urandom_range(0, 3999) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // Drop counter saturation.
        step(1'b0, 20'h0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 20'h0AAAA : 20'h05555, 1'b0, 1'b0);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);

        // Asynchronous reset while entries are pending.
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_out_z", 32'(out_z), 32'd0);
        chk("arst_out_diff", 32'(out_diff), 32'd0);
        chk("arst_out_stamp", 32'(out_stamp), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 20'h0, 1'b0, 1'b1);
        chk("arst_no_ghost", 32'(out_valid), 32'd0);
        step(1'b1, 20'h00ABC, 1'b0, 1'b0);
        chk("arst_restart_stamp", 32'(out_stamp), 32'd0);
        chk("arst_restart_diff", 32'(out_diff), 32'h00ABC);
        step(1'b0, 20'h0, 1'b0, 1'b1);
        step(1'b0, 20'h0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pla_b3_change_queue.md
PLA_B3_CHANGE_QUEUE -- requirements
Module: pla_b3_change_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter STAMP_W, default 12, sample-stamp width in bits.
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, in_z holds a settled 20-bit PLA output word this cycle.
REQ-006 SHALL have port in_z, input, 20, PLA output word z19..z00 (bit n = zNN).
REQ-007 SHALL have port clear, input, 1, synchronous flush.
REQ-008 SHALL have port out_valid, output, 1, head entry available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port out_z, output, 20, captured word.
REQ-011 SHALL have port out_diff, output, 20, bits that changed versus the previous sample.
REQ-012 SHALL have port out_stamp, output, STAMP_W, sample index of the captured word.
REQ-013 SHALL have port overflow, output, 1, sticky, set when an entry is dropped.
REQ-014 SHALL have port drop_cnt, output, 8, saturating count of dropped entries.

Function
REQ-015 SHALL keep a sample counter that increments by 1 on every accepted in_valid and wraps modulo 2^STAMP_W.
REQ-016 SHALL hold a two-state FSM: UNPRIMED (no sample since reset/clear) and PRIMED.
REQ-017 In UNPRIMED, in_valid SHALL enqueue {in_z, diff=in_z, stamp} and move to PRIMED.
REQ-018 In PRIMED, in_valid with in_z != last_z SHALL enqueue {in_z, in_z^last_z, stamp}; an equal word SHALL enqueue nothing.
REQ-019 last_z SHALL update on every accepted in_valid, whether enqueued or not.
REQ-020 The stamp carried SHALL be the counter value before that sample's increment (first sample = 0).
REQ-021 Dequeue SHALL occur when out_valid && out_ready; out_valid SHALL equal FIFO not-empty.
REQ-022 Outputs SHALL come from registers; an enqueue into an empty FIFO at cycle N SHALL show out_valid=1 at cycle N+1.
REQ-023 Head outputs SHALL stay stable while out_valid && !out_ready.
REQ-024 Full with enqueue and no dequeue: entry SHALL be dropped, overflow set, drop_cnt +1 saturating at 255.
REQ-025 Full with enqueue and dequeue in the same cycle: SHALL be accepted, no drop.
REQ-026 Empty with enqueue only: no dequeue occurs; FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 clear SHALL empty the FIFO, zero counter, overflow and drop_cnt, and return to UNPRIMED; clear has priority over a same-cycle in_valid (sample ignored) and dequeue.

Reset
REQ-028 rst_n low SHALL asynchronously force: FIFO empty, out_valid=0, out_z=0, out_diff=0, out_stamp=0, overflow=0, drop_cnt=0, counter=0, last_z=0, FSM=UNPRIMED.
REQ-029 Reset asserted mid-transfer SHALL discard all queued entries; no entry reappears after release.
REQ-030 Outputs SHALL change only on clk edges after rst_n deasserts.

Structure
REQ-031 Shared package pla_b3_pkg SHALL hold Z_W=20, the FSM state enum and the entry struct {z, diff, stamp}.
REQ-032 Storage and pointers SHALL be one sub-module pla_b3_sync_fifo (DEPTH, entry type), instantiated once; change detection, counter and FSM live in the top.
REQ-033 Implementation SHALL fit 120-400 lines of RTL with no latches or combinational paths from in_* to out_*.

Verification
REQ-034 Reset, in_valid with in_z=20'h00001 -> next cycle out_valid=1, out_z=20'h00001, out_diff=20'h00001, out_stamp=0.
REQ-035 Samples 20'h00010, 20'h00010, 20'h00030, out_ready=1 -> two entries: stamps 0 and 2, second out_diff=20'h00020.
REQ-036 out_ready=0, DEPTH=4, six distinct samples -> four entries held, overflow=1, drop_cnt=2, head stamp=0.
REQ-037 FIFO full, out_ready=1, distinct sample same cycle -> no drop, occupancy stays 4, drop_cnt unchanged.
REQ-038 clear asserted with in_valid=1 and three queued entries -> next cycle out_valid=0, overflow=0; following sample gets stamp 0, diff=in_z.
REQ-039 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 immediately (asynchronous), all outputs zero, counter restarts at 0.
